dmem_bus_if: RTL and testbench

//  Data-memory bus interface between the MEM stage and the external data bus
//  (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). Accepts one load/store per access.

---
 rtl/dmem_bus_if_if.sv | 11 +
 rtl/dmem_bus_if.sv | 133 +++++++++++++
 tb/tb_dmem_bus_if.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_if_if.sv
// dmem_bus_if_if: external data-bus control signals (address, request, write, size, active-low ack)
// master: the bus interface block driving DAD/MREQ/WRITE/SIZE; slave: memory side returning ACKD_n
interface dmem_bus_if_if;
  logic [31:0] DAD;
  logic MREQ;
  logic WRITE;
  logic [1:0] SIZE;
  logic ACKD_n;
  modport master(output DAD, MREQ, WRITE, SIZE, input ACKD_n);
  modport slave(input DAD, MREQ, WRITE, SIZE, output ACKD_n);
endinterface

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: MEM-stage data bus interface, ACKD_n handshake, store lane alignment, load extract/extend
// ports: clk, rst (sync, active high); req_read/req_write/req_addr/req_wdata/req_size/req_unsigned from the pipeline;
// stall, done, rdata, misalign, timeout_err back to the pipeline; DDT tri-state data bus; bus (master modport) carries DAD/MREQ/WRITE/SIZE/ACKD_n
// DMEM_TIMEOUT_EN enables the BUSY-cycle timeout abort (TIMEOUT_CYCLES, TO_W)
module dmem_bus_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_read,
  input  logic req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0] req_size,
  input  logic req_unsigned,
  output logic stall,
  output logic done,
  output logic [31:0] rdata,
  output logic misalign,
  output logic timeout_err,
  inout  wire [31:0] DDT,
  dmem_bus_if_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st;
  logic req, aligned, uns;
  logic [31:0] lanes, wdat, ld;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  if (TIMEOUT_CYCLES >= 2 ** TO_W || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("TIMEOUT_CYCLES must be in 1 .. 2**TO_W-1");
  end
  assign req = req_read | req_write;
  assign aligned = req_size == 2'b00 ? 1'b1 : req_size == 2'b01 ? !req_addr[0] : req_addr[1:0] == 2'b00;
  assign lanes = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign stall = st == BUSY || (st == IDLE && req && aligned);
  // WRITE is only high in BUSY for stores, so it doubles as the DDT drive enable
  assign DDT = bus.WRITE ? wdat : 32'hzzzz_zzzz;
  // DAD/SIZE hold the latched address/size for the whole access
  assign byte_v = 8'(DDT >> {bus.DAD[1:0], 3'b000});
  assign half_v = bus.DAD[1] ? DDT[31:16] : DDT[15:0];
  assign ld = bus.SIZE == 2'b00 ? {{24{!uns & byte_v[7]}}, byte_v} :
              bus.SIZE == 2'b01 ? {{16{!uns & half_v[15]}}, half_v} : DDT;
`ifdef DMEM_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      bus.MREQ <= 1'b0;
      bus.WRITE <= 1'b0;
      bus.DAD <= '0;
      bus.SIZE <= 2'b10;
      rdata <= '0;
      done <= 1'b0;
      misalign <= 1'b0;
      timeout_err <= 1'b0;
      wdat <= '0;
      uns <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      misalign <= 1'b0;
      timeout_err <= 1'b0;
      case (st)
        IDLE: if (req && aligned) begin
          st <= BUSY;
          bus.MREQ <= 1'b1;
          bus.WRITE <= req_write;
          bus.DAD <= req_addr;
          bus.SIZE <= req_size;
          uns <= req_unsigned;
          wdat <= lanes;
          cnt <= '0;
        end else misalign <= req;
        BUSY: if (!bus.ACKD_n) begin
          st <= DONE;
          bus.MREQ <= 1'b0;
          bus.WRITE <= 1'b0;
          done <= 1'b1;
          if (!bus.WRITE) rdata <= ld;
        end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          st <= DONE;
          bus.MREQ <= 1'b0;
          bus.WRITE <= 1'b0;
          done <= 1'b1;
          timeout_err <= 1'b1;
          rdata <= '0;
        end else cnt <= cnt + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      bus.MREQ <= 1'b0;
      bus.WRITE <= 1'b0;
      bus.DAD <= '0;
      bus.SIZE <= 2'b10;
      rdata <= '0;
      done <= 1'b0;
      misalign <= 1'b0;
      wdat <= '0;
      uns <= 1'b0;
    end else begin
      done <= 1'b0;
      misalign <= 1'b0;
      case (st)
        IDLE: if (req && aligned) begin
          st <= BUSY;
          bus.MREQ <= 1'b1;
          bus.WRITE <= req_write;
          bus.DAD <= req_addr;
          bus.SIZE <= req_size;
          uns <= req_unsigned;
          wdat <= lanes;
        end else misalign <= req;
        BUSY: if (!bus.ACKD_n) begin
          st <= DONE;
          bus.MREQ <= 1'b0;
          bus.WRITE <= 1'b0;
          done <= 1'b1;
          if (!bus.WRITE) rdata <= ld;
        end
        default: st <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed self-checking bench for dmem_bus_if
module tb_dmem_bus_if;
  logic clk = 1'b0;
  logic rst, req_read, req_write, req_unsigned, stall, done, misalign, timeout_err;
  logic [31:0] req_addr, req_wdata, rdata;
  logic [1:0] req_size;
  logic tb_en;
  logic [31:0] tb_ddt;
  wire [31:0] DDT;
  int n_chk = 0, n_fail = 0;
  dmem_bus_if_if bus();
  assign DDT = tb_en ? tb_ddt : 32'hzzzz_zzzz;
`ifdef DMEM_TIMEOUT_EN
  dmem_bus_if #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
`else
  dmem_bus_if dut (
`endif
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .stall(stall),
    .done(done), .rdata(rdata), .misalign(misalign), .timeout_err(timeout_err), .DDT(DDT), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic wr, input logic [31:0] addr, wd, input logic [1:0] sz, input logic uns,
                     input int ack_at, input logic [31:0] bus_data, exp_rd, exp_ddt);
    int m = 0;
    req_write = wr;
    req_read = !wr;
    req_addr = addr;
    req_wdata = wd;
    req_size = sz;
    req_unsigned = uns;
    #1 check("stall_accept", stall, 1);
    @(negedge clk);
    check("dad", bus.DAD, addr);
    check("size", 32'(bus.SIZE), 32'(sz));
    check("write", 32'(bus.WRITE), 32'(wr));
    if (wr) check("ddt_store", DDT, exp_ddt);
    for (int i = 1; i <= ack_at; i++) begin
      m += int'(bus.MREQ);
      check("stall_busy", stall, 1);
      if (i == ack_at) begin
        bus.ACKD_n = 1'b0;
        if (!wr) begin
          tb_en = 1'b1;
          tb_ddt = bus_data;
        end
      end
      @(negedge clk);
    end
    bus.ACKD_n = 1'b1;
    tb_en = 1'b1;
    tb_ddt = 32'h0;
    #1;
    check("mreq_cycles", m, ack_at);
    check("done", done, 1);
    check("stall_done", stall, 0);
    check("mreq_done", bus.MREQ, 0);
    check("write_done", bus.WRITE, 0);
    check("rdata", rdata, exp_rd);
    check("timeout_err", timeout_err, 0);
    check("ddt_released", DDT, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("no_reissue", bus.MREQ, 0);
    req_read = 1'b0;
    req_write = 1'b0;
    tb_en = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int m, d;
    rst = 1'b1;
    req_read = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    bus.ACKD_n = 1'b1;
    tb_en = 1'b0;
    tb_ddt = '0;
    repeat (2) @(negedge clk);
    check("rst_mreq", bus.MREQ, 0);
    check("rst_write", bus.WRITE, 0);
    check("rst_dad", bus.DAD, 0);
    check("rst_size", 32'(bus.SIZE), 2);
    check("rst_rdata", rdata, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_misalign", misalign, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    bus.ACKD_n = 1'b0;
    @(negedge clk);
    check("idle_ack_done", done, 0);
    check("idle_ack_mreq", bus.MREQ, 0);
    bus.ACKD_n = 1'b1;
    run(0, 32'h100, 0, 2'b10, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    run(0, 32'h103, 0, 2'b00, 0, 1, 32'h80123456, 32'hFFFFFF80, 0);
    run(0, 32'h103, 0, 2'b00, 1, 1, 32'h80123456, 32'h00000080, 0);
    run(0, 32'h102, 0, 2'b01, 1, 1, 32'h80123456, 32'h00008012, 0);
    run(0, 32'h100, 0, 2'b01, 0, 2, 32'h0000F00D, 32'hFFFFF00D, 0);
    run(1, 32'h102, 32'h1234ABCD, 2'b01, 0, 1, 0, 32'hFFFFF00D, 32'hABCDABCD);
    run(1, 32'h001, 32'h0000005A, 2'b00, 0, 2, 0, 32'hFFFFF00D, 32'h5A5A5A5A);
    req_read = 1'b1;
    req_addr = 32'h101;
    req_size = 2'b10;
    #1 check("misalign_stall", stall, 0);
    @(negedge clk);
    req_read = 1'b0;
    check("misalign_pulse", misalign, 1);
    check("misalign_mreq", bus.MREQ, 0);
    @(negedge clk);
    check("misalign_clear", misalign, 0);
    run(0, 32'h108, 0, 2'b11, 0, 1, 32'h12345678, 32'h12345678, 0);
`ifdef DMEM_TIMEOUT_EN
    req_read = 1'b1;
    req_addr = 32'h300;
    req_size = 2'b10;
    m = 0;
    @(negedge clk);
    while (!done && m < 20) begin
      m += int'(bus.MREQ);
      @(negedge clk);
    end
    check("to_busy_cycles", m, 4);
    check("to_done", done, 1);
    check("to_err", timeout_err, 1);
    check("to_rdata", rdata, 0);
    check("to_stall", stall, 0);
    req_read = 1'b0;
    @(negedge clk);
    check("to_err_pulse", timeout_err, 0);
`else
    run(0, 32'h300, 0, 2'b10, 0, 10, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0);
`endif
    req_write = 1'b1;
    req_addr = 32'h200;
    req_wdata = 32'h11223344;
    req_size = 2'b10;
    repeat (2) @(negedge clk);
    check("rst_busy_ddt", DDT, 32'h11223344);
    check("rst_busy_mreq", bus.MREQ, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_write = 1'b0;
    tb_en = 1'b1;
    tb_ddt = 32'h0;
    #1;
    check("abort_mreq", bus.MREQ, 0);
    check("abort_ddt", DDT, 0);
    check("abort_stall", stall, 0);
    tb_en = 1'b0;
    d = 0;
    repeat (4) begin
      d += int'(done);
      @(negedge clk);
    end
    check("abort_no_done", d, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
